// File: rtl/exp_lut_sram.sv
// Table store for the FP32 SRAM exp datapath.
// Holds the hi table ({E_adj, M_hi, S}) and the lo table ({E_adj, M_lo, S}).
// A streaming loader fills hi first, then lo. After that, lookups return both
// words one cycle after the indices are presented.
module exp_lut_sram #(
  parameter int HI_AW = 16,
  parameter int LO_AW = 17,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [DW-1:0]     load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              tables_ready,
  output logic [LO_AW:0]    load_count,
  input  logic              lk_valid,
  input  logic [HI_AW-1:0]  sram_hi_idx,
  input  logic [LO_AW-1:0]  sram_lo_idx,
  output logic [DW-1:0]     sram_hi,
  output logic [DW-1:0]     sram_lo,
  output logic              lk_out_valid
);

  typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, READY} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [LO_AW-1:0]    r_wr_addr;
  logic [LO_AW:0]      r_load_count;
  logic                w_load_ready;
  logic                w_tables_ready;
  logic                w_accept;
  logic                w_start;
  logic [HI_AW-1:0]    w_hi_waddr;
  logic                w_hi_last;
  logic                w_lo_last;

  logic [DW-1:0]       r_hi_mem [2**HI_AW];
  logic [DW-1:0]       r_lo_mem [2**LO_AW];

  logic [DW-1:0]       r_sram_hi_p1;
  logic [DW-1:0]       r_sram_lo_p1;
  logic                r_vld_p1;

  // The beat counter sticks at all-ones instead of wrapping.
  function automatic logic [LO_AW:0] sat_inc(input logic [LO_AW:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // While loading hi, the upper write-address bits stay zero.
  assign w_hi_waddr = r_wr_addr[HI_AW-1:0];
  assign w_hi_last  = &w_hi_waddr;
  assign w_lo_last  = &r_wr_addr;
  assign w_accept   = load_valid & w_load_ready;
  assign w_start    = load_start & ((r_state == IDLE) | (r_state == READY));

  // Next-state and status decode for the loader.
  always_comb begin
    w_next_state   = r_state;
    w_load_ready   = 1'b0;
    w_tables_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start) w_next_state = LOAD_HI;
      end
      LOAD_HI: begin
        w_load_ready = 1'b1;
        if (load_valid && w_hi_last) w_next_state = LOAD_LO;
      end
      LOAD_LO: begin
        w_load_ready = 1'b1;
        if (load_valid && w_lo_last) w_next_state = READY;
      end
      READY: begin
        w_tables_ready = 1'b1;
        if (load_start) w_next_state = LOAD_HI;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Loader state, write address and accepted-beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_addr    <= '0;
      r_load_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_wr_addr    <= '0;
        r_load_count <= '0;
      end else if (w_accept) begin
        r_load_count <= sat_inc(r_load_count);
        if (r_state == LOAD_HI && w_hi_last) r_wr_addr <= '0;
        else                                 r_wr_addr <= r_wr_addr + 1'b1;
      end
    end
  end

  // Table writes. Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_accept && r_state == LOAD_HI) r_hi_mem[w_hi_waddr] <= load_data;
    if (w_accept && r_state == LOAD_LO) r_lo_mem[r_wr_addr]  <= load_data;
  end

  // Lookup stage p1. A read can never overlap a write, because reads need READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_hi_p1 <= '0;
      r_sram_lo_p1 <= '0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_vld_p1 <= lk_valid & w_tables_ready;
      if (lk_valid && w_tables_ready) begin
        r_sram_hi_p1 <= r_hi_mem[sram_hi_idx];
        r_sram_lo_p1 <= r_lo_mem[sram_lo_idx];
      end
    end
  end

  assign load_ready   = w_load_ready;
  assign tables_ready = w_tables_ready;
  assign load_count   = r_load_count;
  assign sram_hi      = r_sram_hi_p1;
  assign sram_lo      = r_sram_lo_p1;
  assign lk_out_valid = r_vld_p1;

endmodule

// File: doc/exp_lut_sram.md
Name: exp_lut_sram

Overview:
- Table store that feeds the FP32 SRAM exp datapath.
- Holds the hi table (indexed {E_adj, M_hi, S}) and the lo table (indexed {E_adj, M_lo, S}).
- A streaming loader fills both tables after reset. The lookup port then returns both table words one cycle after the indices are presented, for the downstream FP32 multiply.

Parameters:
- HI_AW, 16, hi table address width (depth 2^HI_AW).
- LO_AW, 17, lo table address width (depth 2^LO_AW).
- DW, 32, table word width (FP32).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- load_start  input  1  pulse; begins a full table load.
- load_data  input  DW  load beat payload.
- load_valid  input  1  load beat valid.
- load_ready  output  1  block accepts a load beat.
- tables_ready  output  1  both tables fully loaded; lookups are valid.
- load_count  output  LO_AW+1  number of beats accepted in the current or last load.
- lk_valid  input  1  lookup request valid.
- sram_hi_idx  input  HI_AW  hi table index.
- sram_lo_idx  input  LO_AW  lo table index.
- sram_hi  output  DW  hi table word.
- sram_lo  output  DW  lo table word.
- lk_out_valid  output  1  sram_hi/sram_lo are valid this cycle.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE.
  - load_ready=0, tables_ready=0, load_count=0.
  - sram_hi=0, sram_lo=0, lk_out_valid=0.
  - Table contents are not cleared.
- FSM states: IDLE, LOAD_HI, LOAD_LO, READY.
- IDLE:
  - load_start=1 goes to LOAD_HI with wr_addr=0 and load_count=0.
  - Otherwise stay in IDLE.
- LOAD_HI:
  - load_ready=1.
  - A beat is accepted when load_valid & load_ready. It writes hi[wr_addr]=load_data, then wr_addr++ and load_count++.
  - An accepted beat at wr_addr=2^HI_AW-1 goes to LOAD_LO with wr_addr=0.
- LOAD_LO:
  - Same beat rules, writing the lo table.
  - An accepted beat at wr_addr=2^LO_AW-1 goes to READY.
  - In that same edge, tables_ready goes to 1 and load_ready goes to 0.
- READY:
  - tables_ready=1, load_ready=0.
  - load_start=1 goes to LOAD_HI and clears tables_ready, so the reload starts from scratch.
- load_start during LOAD_HI or LOAD_LO is ignored; there is no restart mid-load.
- load_valid with no beat pending (IDLE/READY) is ignored.
- Beat stalls (load_valid=0) hold wr_addr and state indefinitely; there is no timeout.
- The load sequence is strictly all hi beats, then all lo beats: 2^HI_AW + 2^LO_AW beats total.
- load_count:
  - Saturates at its width and never wraps.
  - Holds its final value in READY.
- Lookup:
  - Synchronous read with 1-cycle latency.
  - If lk_valid=1 and tables_ready=1 at edge N: at edge N+1, sram_hi=hi[sram_hi_idx], sram_lo=lo[sram_lo_idx] and lk_out_valid=1.
  - Otherwise at edge N+1, lk_out_valid=0 and sram_hi/sram_lo hold their previous values.
  - Full throughput: one lookup per cycle, back-to-back.
  - Lookups while not tables_ready are dropped; no stall or backpressure.
- Index out of range: indices are exactly HI_AW/LO_AW bits wide, so every index is in range.
- Simultaneous load_start and lk_valid in READY:
  - The lookup presented in that cycle completes with the old contents (lk_out_valid=1 next cycle).
  - tables_ready drops at the same edge, so later lookups are dropped.
- Reset mid-load:
  - Returns to IDLE with tables_ready=0.
  - Partially written contents are unspecified until a full reload.
- Each table is one write port plus one read port. Write and read never coincide in the same table, because reads require tables_ready.

Test Plan:
- HI_AW=3, LO_AW=4. After reset, check load_ready=0, tables_ready=0 and lk_out_valid=0. Issue load_start, stream 8+16 beats with data=0x3F800000+i, no stalls. Required: tables_ready rises on the edge accepting beat 24, load_count=24.
- Same parameters, with load_valid toggling every other cycle. Required: exactly 24 accepted beats, and the LOAD_HI→LOAD_LO switch happens after beat 8.
- After the load, issue lookups with hi_idx=5, lo_idx=11 and then hi_idx=0, lo_idx=15 back-to-back.
  - Required: the next cycles show sram_hi=0x3F800005, sram_lo=0x3F800013, then sram_hi=0x3F800000, sram_lo=0x3F800017.
  - lk_out_valid=1 on both cycles.
- lk_valid=1 before the load completes. Required: lk_out_valid stays 0 and sram_hi/sram_lo stay 0.
- Pulse load_start in mid-LOAD_LO. Required: it is ignored and load_count continues incrementing. Then load_start in READY together with lk_valid=1. Required: that lookup returns old data with lk_out_valid=1, tables_ready=0 at the same edge, and a new load begins at hi[0].
- Assert rst during LOAD_HI after 3 beats. Required: next cycle state is IDLE, load_ready=0, load_count=0, tables_ready=0, and lookups are dropped.
